// File: rtl/xbus_arbiter_if.sv
// rtl/xbus_arbiter_if.sv - XBus request/acknowledge bundle between the MC ports and the arbiter.
interface xbus_arbiter_if #(
  parameter int N_PORTS = 4,
  parameter int DATA_W  = 11
);
  logic [N_PORTS-1:0]        wr_req;
  logic [N_PORTS*DATA_W-1:0] wr_data;
  logic [N_PORTS-1:0]        rd_req;
  logic [N_PORTS-1:0]        wr_ack;
  logic [N_PORTS-1:0]        rd_ack;
  logic [DATA_W-1:0]         rd_data;

  modport slave (
    input  wr_req, wr_data, rd_req,
    output wr_ack, rd_ack, rd_data
  );

  modport master (
    output wr_req, wr_data, rd_req,
    input  wr_ack, rd_ack, rd_data
  );
endinterface

// File: rtl/xbus_arbiter.sv
// rtl/xbus_arbiter.sv - Pairs one writer with one reader per XBus transfer, with stall/deadlock tracking.
// Define XBUS_ROUND_ROBIN_EN for rotating writer/reader priority; otherwise lowest index wins.
module xbus_arbiter #(
  parameter int N_PORTS     = 4,
  parameter int DATA_W      = 11,
  parameter int STALL_LIMIT = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          posedge_big_clk,
  xbus_arbiter_if.slave bus,
  output logic          busy,
  output logic          deadlock,
  output logic [15:0]   xfer_count
);
  localparam int IDX_W = $clog2(N_PORTS);

  typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_RECOVER} state_t;

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         w_q, w_d, r_q, r_d;
  logic [DATA_W-1:0]        data_q, data_d;
  logic [3:0]               stall_q, stall_d;
  logic                     seen_q, seen_d;
  logic [15:0]              count_q, count_d;

  logic [N_PORTS-1:0]       eff_wr, eff_rd;
  logic                     wr_found, rd_found, grant;
  logic [IDX_W-1:0]         wr_sel, rd_sel;
  logic signed [DATA_W-1:0] raw;
  logic [DATA_W-1:0]        sat_data;

  // A port raising both requests is a writer; masking its read also keeps r != w.
  assign eff_wr = bus.wr_req;
  assign eff_rd = bus.rd_req & ~bus.wr_req;

`ifdef XBUS_ROUND_ROBIN_EN
  logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

  always_comb begin
    wr_found = 1'b0;
    wr_sel   = '0;
    rd_found = 1'b0;
    rd_sel   = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      if (!wr_found && eff_wr[(int'(wr_ptr_q) + k) % N_PORTS]) begin
        wr_found = 1'b1;
        wr_sel   = IDX_W'((int'(wr_ptr_q) + k) % N_PORTS);
      end
      if (!rd_found && eff_rd[(int'(rd_ptr_q) + k) % N_PORTS]) begin
        rd_found = 1'b1;
        rd_sel   = IDX_W'((int'(rd_ptr_q) + k) % N_PORTS);
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (grant) begin
      wr_ptr_d = IDX_W'((int'(wr_sel) + 1) % N_PORTS);
      rd_ptr_d = IDX_W'((int'(rd_sel) + 1) % N_PORTS);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
`else
  always_comb begin
    wr_found = 1'b0;
    wr_sel   = '0;
    rd_found = 1'b0;
    rd_sel   = '0;
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      if (eff_wr[k]) begin
        wr_found = 1'b1;
        wr_sel   = IDX_W'(k);
      end
      if (eff_rd[k]) begin
        rd_found = 1'b1;
        rd_sel   = IDX_W'(k);
      end
    end
  end
`endif

  always_comb begin
    raw = bus.wr_data[wr_sel*DATA_W +: DATA_W];
    if (int'(raw) > 999) begin
      sat_data = DATA_W'(999);
    end else if (int'(raw) < -999) begin
      sat_data = DATA_W'(-999);
    end else begin
      sat_data = raw;
    end
  end

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    r_d     = r_q;
    data_d  = data_q;
    stall_d = stall_q;
    seen_d  = seen_q;
    count_d = count_q;
    grant   = 1'b0;

    if (posedge_big_clk) begin
      if ((|(eff_wr | eff_rd)) && !seen_q) begin
        stall_d = (stall_q == 4'(STALL_LIMIT)) ? stall_q : stall_q + 4'd1;
      end else begin
        stall_d = '0;
      end
      seen_d = 1'b0;
    end

    // Grant and XFER both count as transfer activity, overriding any tick.
    case (state_q)
      ST_IDLE: begin
        if (wr_found && rd_found) begin
          grant   = 1'b1;
          state_d = ST_XFER;
          w_d     = wr_sel;
          r_d     = rd_sel;
          data_d  = sat_data;
          count_d = count_q + 16'd1;
          stall_d = '0;
          seen_d  = 1'b1;
        end
      end
      ST_XFER: begin
        state_d = ST_RECOVER;
        stall_d = '0;
        seen_d  = 1'b1;
      end
      ST_RECOVER: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      w_q     <= '0;
      r_q     <= '0;
      data_q  <= '0;
      stall_q <= '0;
      seen_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      r_q     <= r_d;
      data_q  <= data_d;
      stall_q <= stall_d;
      seen_q  <= seen_d;
      count_q <= count_d;
    end
  end

  // Outputs decode from state so an asynchronous reset drops the acks at once.
  assign bus.wr_ack  = (state_q == ST_XFER) ? ({{(N_PORTS-1){1'b0}}, 1'b1} << w_q) : '0;
  assign bus.rd_ack  = (state_q == ST_XFER) ? ({{(N_PORTS-1){1'b0}}, 1'b1} << r_q) : '0;
  assign bus.rd_data = (state_q == ST_XFER) ? data_q : '0;
  assign busy        = (state_q != ST_IDLE);
  assign deadlock    = (stall_q == 4'(STALL_LIMIT));
  assign xfer_count  = count_q;
endmodule

// File: tb/tb_xbus_arbiter.sv
// tb/tb_xbus_arbiter.sv - Directed and randomized self-checking bench for xbus_arbiter.
// Build with +define+XBUS_ROUND_ROBIN_EN to check the rotating-priority variant.
`timescale 1ns/1ps
module tb_xbus_arbiter;
  localparam int N   = 4;
  localparam int DW  = 11;
  localparam int LIM = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        posedge_big_clk = 1'b0;
  logic        busy, deadlock;
  logic [15:0] xfer_count;
  int          n_checks = 0;
  int          n_pass = 0;

  logic [1:0]  kinds [N];
  int          vals  [N];
  int          m_phase, m_w, m_r, m_val, m_stall, m_wptr, m_rptr, m_count;
  bit          m_seen;

  xbus_arbiter_if #(.N_PORTS(N), .DATA_W(DW)) bus ();

  xbus_arbiter #(.N_PORTS(N), .DATA_W(DW), .STALL_LIMIT(LIM)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .posedge_big_clk (posedge_big_clk),
    .bus             (bus),
    .busy            (busy),
    .deadlock        (deadlock),
    .xfer_count      (xfer_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] w11(input int v);
    return v & ((1 << DW) - 1);
  endfunction

  function automatic int clamp(input int v);
    return (v > 999) ? 999 : ((v < -999) ? -999 : v);
  endfunction

  function automatic int pick(input logic [N-1:0] set, input int start);
    for (int k = 0; k < N; k++) if (set[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic [1:0] kind, input int val);
    bus.wr_req[p] = kind[0];
    bus.rd_req[p] = kind[1];
    bus.wr_data[p*DW +: DW] = DW'(val);
  endtask

  task automatic clear_ports();
    bus.wr_req  = '0;
    bus.rd_req  = '0;
    bus.wr_data = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_ports();
    next_cycle();
    rst_n = 1'b1;
  endtask

  // Entered at posedge+1 with the arbiter idle; returns at posedge+1 idle again.
  task automatic do_xfer(input string tag, input int wp, input logic [1:0] wkind, input int val,
                         input int rp, input int exp_data);
    set_port(wp, wkind, val);
    set_port(rp, 2'b10, 0);
    @(negedge clk);
    @(negedge clk);
    check({tag, "_wr_ack"}, 32'(bus.wr_ack), 1 << wp);
    check({tag, "_rd_ack"}, 32'(bus.rd_ack), 1 << rp);
    check({tag, "_rd_data"}, 32'(bus.rd_data), w11(exp_data));
    next_cycle();
    clear_ports();
    @(negedge clk);
    next_cycle();
  endtask

  task automatic wait_ack(input int limit, output bit ok, output int waited);
    ok = 1'b0;
    waited = 0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      waited++;
      if (bus.wr_ack != '0) ok = 1'b1;
    end
  endtask

  task automatic model_step();
    logic [N-1:0] ew, er;
    int w, r;
    for (int p = 0; p < N; p++) begin
      ew[p] = kinds[p][0];
      er[p] = kinds[p][1] & ~kinds[p][0];
    end
    if (posedge_big_clk) begin
      if ((ew | er) != '0 && !m_seen) m_stall = (m_stall < LIM) ? m_stall + 1 : LIM;
      else m_stall = 0;
      m_seen = 1'b0;
    end
    if (m_phase == 1) begin
      m_stall = 0;
      m_seen  = 1'b1;
      m_phase = 2;
    end else if (m_phase == 2) begin
      m_phase = 0;
    end else begin
      w = pick(ew, m_wptr);
      r = pick(er, m_rptr);
      if (w >= 0 && r >= 0) begin
        m_phase = 1;
        m_w     = w;
        m_r     = r;
        m_val   = clamp(vals[w]);
        m_count = (m_count + 1) % 65536;
        m_stall = 0;
        m_seen  = 1'b1;
`ifdef XBUS_ROUND_ROBIN_EN
        m_wptr  = (w + 1) % N;
        m_rptr  = (r + 1) % N;
`endif
      end
    end
  endtask

  initial begin
    bit          ok, any_ack;
    int          waited, exp_p;
    logic [N-1:0] exp_wack, exp_rack;

    clear_ports();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_acks", {bus.wr_ack, bus.rd_ack}, '0);
    check("rst_status", {busy, deadlock, xfer_count}, '0);
    check("rst_rd_data", 32'(bus.rd_data), 0);
    next_cycle();
    rst_n = 1'b1;

    // Port 0 writes 42 to port 2; acks appear one cycle after the sampling edge.
    set_port(0, 2'b01, 42);
    set_port(2, 2'b10, 0);
    @(negedge clk);
    check("lat_pre_ack", {bus.wr_ack, bus.rd_ack}, '0);
    @(negedge clk);
    check("basic_wr_ack", 32'(bus.wr_ack), 32'b0001);
    check("basic_rd_ack", 32'(bus.rd_ack), 32'b0100);
    check("basic_rd_data", 32'(bus.rd_data), 42);
    check("basic_count", 32'(xfer_count), 1);
    check("basic_busy1", 32'(busy), 1);
    next_cycle();
    clear_ports();
    @(negedge clk);
    check("recover_busy", 32'(busy), 1);
    check("recover_quiet", {bus.wr_ack, bus.rd_ack, bus.rd_data}, '0);
    @(negedge clk);
    check("idle_busy", 32'(busy), 0);
    next_cycle();

    do_xfer("sat_hi", 1, 2'b01, 1023, 3, 999);
    do_xfer("sat_lo", 1, 2'b01, -1024, 3, -999);
    do_xfer("edge_p999", 0, 2'b01, 999, 1, 999);
    do_xfer("edge_m999", 2, 2'b01, -999, 0, -999);
    do_xfer("edge_1000", 3, 2'b01, 1000, 2, 999);
    do_xfer("small_neg", 1, 2'b01, -5, 0, -5);
    @(negedge clk);
    check("count_7", 32'(xfer_count), 7);
    next_cycle();

    // Lone reader, then a port requesting both on its own: neither may transfer.
    set_port(3, 2'b10, 0);
    repeat (5) @(negedge clk);
    check("lone_reader", {busy, bus.wr_ack, bus.rd_ack}, '0);
    next_cycle();
    clear_ports();
    set_port(0, 2'b11, 9);
    repeat (5) @(negedge clk);
    check("self_read", {busy, bus.wr_ack, bus.rd_ack}, '0);
    next_cycle();
    clear_ports();

    // Two continuous writers and one continuous reader.
    do_reset();
    set_port(0, 2'b01, 5);
    set_port(1, 2'b01, -7);
    set_port(3, 2'b10, 0);
    for (int k = 0; k < 4; k++) begin
      wait_ack(8, ok, waited);
      check("arb_ack_seen", 32'(ok), 1);
`ifdef XBUS_ROUND_ROBIN_EN
      exp_p = k % 2;
`else
      exp_p = 0;
`endif
      check("arb_grant", 32'(bus.wr_ack), 1 << exp_p);
      check("arb_data", 32'(bus.rd_data), w11(exp_p == 1 ? -7 : 5));
      if (k == 0) check("arb_first_wait", 32'(waited), 2);
      else check("arb_interval", 32'(waited), 3);
    end
    next_cycle();
    clear_ports();
    @(negedge clk);
    next_cycle();

    // Flush the transfer-seen interval, then stall a lone writer across ticks.
    posedge_big_clk = 1'b1;
    next_cycle();
    posedge_big_clk = 1'b0;
    set_port(2, 2'b01, 77);
    for (int t = 1; t <= 4; t++) begin
      posedge_big_clk = 1'b1;
      next_cycle();
      posedge_big_clk = 1'b0;
      @(negedge clk);
      check("stall_deadlock", 32'(deadlock), (t >= 3) ? 1 : 0);
      next_cycle();
    end
    set_port(0, 2'b10, 0);
    @(negedge clk);
    check("dl_before_xfer", 32'(deadlock), 1);
    @(negedge clk);
    check("dl_in_xfer", 32'(deadlock), 0);
    check("dl_wr_ack", 32'(bus.wr_ack), 32'b0100);
    check("dl_rd_ack", 32'(bus.rd_ack), 32'b0001);
    check("dl_rd_data", 32'(bus.rd_data), 77);
    next_cycle();
    clear_ports();
    @(negedge clk);
    next_cycle();

    // Reset asserted in the middle of an XFER cycle.
    set_port(0, 2'b01, 3);
    set_port(1, 2'b10, 0);
    @(negedge clk);
    @(negedge clk);
    check("rx_in_xfer", 32'(bus.wr_ack), 32'b0001);
    #1;
    rst_n = 1'b0;
    #1;
    check("rx_acks_drop", {bus.wr_ack, bus.rd_ack, bus.rd_data}, '0);
    check("rx_status", {busy, deadlock, xfer_count}, '0);
    clear_ports();
    next_cycle();
    rst_n = 1'b1;
    any_ack = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if ({bus.wr_ack, bus.rd_ack} != '0) any_ack = 1'b1;
    end
    check("rx_no_late_ack", 32'(any_ack), 0);
    next_cycle();
    do_xfer("wr_only", 0, 2'b11, 12, 1, 12);
    @(negedge clk);
    check("rx_count", 32'(xfer_count), 1);
    next_cycle();

    // Randomized traffic against the reference model.
    do_reset();
    m_phase = 0; m_w = 0; m_r = 0; m_val = 0; m_stall = 0;
    m_wptr = 0; m_rptr = 0; m_count = 0; m_seen = 1'b0;
    exp_wack = '0;
    exp_rack = '0;
    for (int p = 0; p < N; p++) begin
      kinds[p] = 2'b00;
      vals[p]  = 0;
    end
    for (int c = 0; c < 600; c++) begin
      for (int p = 0; p < N; p++) begin
        if (exp_wack[p] || exp_rack[p]) kinds[p] = 2'b00;
        if (kinds[p] == 2'b00 && $urandom_range(0, (c % 200 < 100) ? 3 : 12) == 0) begin
          kinds[p] = 2'($urandom_range(1, 3));
          vals[p]  = int'($urandom_range(0, 2047)) - 1024;
        end
        set_port(p, kinds[p], vals[p]);
      end
      posedge_big_clk = ($urandom_range(0, 4) == 0);
      @(negedge clk);
      exp_wack = (m_phase == 1) ? N'(1 << m_w) : '0;
      exp_rack = (m_phase == 1) ? N'(1 << m_r) : '0;
      check("rnd_acks", {bus.wr_ack, bus.rd_ack}, {exp_wack, exp_rack});
      check("rnd_rd_data", 32'(bus.rd_data), (m_phase == 1) ? w11(m_val) : 0);
      check("rnd_status", {busy, deadlock, xfer_count},
            {(m_phase != 0), (m_stall == LIM), 16'(m_count)});
      model_step();
      next_cycle();
    end
    posedge_big_clk = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
